// File: rtl/cache_ctrl_if.sv
// CPU / cache-array / main-memory signal bundle for cache_ctrl.
// The master modport is the controller side; slave is the CPU, array and memory side.
interface cache_ctrl_if #(
  parameter int ADDR_BITS = 32,
  parameter int WORD_BITS = 32,
  parameter int TAG_BITS  = 22
);
  logic                 cpu_en;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [WORD_BITS-1:0] cpu_din;
  logic [WORD_BITS-1:0] cpu_dout;
  logic                 cpu_stall;

  logic [ADDR_BITS-1:0] cache_addr;
  logic                 cache_store;
  logic                 cache_edit;
  logic [WORD_BITS-1:0] cache_din;
  logic                 cache_hit;
  logic                 cache_valid;
  logic                 cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;
  logic [WORD_BITS-1:0] cache_dout;

  logic                 mem_cs;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_BITS-1:0] mem_dout;
  logic [WORD_BITS-1:0] mem_din;
  logic                 mem_ack;

  modport master (
    input  cpu_en, cpu_we, cpu_addr, cpu_din,
    input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    input  mem_din, mem_ack,
    output cpu_dout, cpu_stall,
    output cache_addr, cache_store, cache_edit, cache_din,
    output mem_cs, mem_we, mem_addr, mem_dout
  );

  modport slave (
    output cpu_en, cpu_we, cpu_addr, cpu_din,
    output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    output mem_din, mem_ack,
    input  cpu_dout, cpu_stall,
    input  cache_addr, cache_store, cache_edit, cache_din,
    input  mem_cs, mem_we, mem_addr, mem_dout
  );
endinterface

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped cache array.
// Optional hit/miss statistics counters are enabled with `define CACHE_CTRL_STAT_EN.
module cache_ctrl #(
  parameter int ADDR_BITS        = 32,
  parameter int WORD_BITS        = 32,
  parameter int TAG_BITS         = 22,
  parameter int WORD_BYTES_WIDTH = 2,
  parameter int LINE_WORDS_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_CTRL_STAT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  cache_ctrl_if.master bus
);

  localparam int INDEX_BITS = ADDR_BITS - TAG_BITS - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH;
  localparam int INDEX_LSB  = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BACKUP,
    ST_FILL,
    ST_WAIT
  } state_t;

  state_t                      r_state;
  logic [LINE_WORDS_WIDTH-1:0] r_cnt;
  logic [TAG_BITS-1:0]         r_victim_tag;

  logic [INDEX_BITS-1:0] w_cpu_idx;
  logic [TAG_BITS-1:0]   w_cpu_tag;
  logic [ADDR_BITS-1:0]  w_backup_addr;
  logic [ADDR_BITS-1:0]  w_fill_addr;
  logic                  w_idle_hit;
  logic                  w_idle_miss;

  assign w_cpu_idx     = bus.cpu_addr[INDEX_LSB +: INDEX_BITS];
  assign w_cpu_tag     = bus.cpu_addr[ADDR_BITS-1 -: TAG_BITS];
  assign w_backup_addr = {r_victim_tag, w_cpu_idx, r_cnt, {WORD_BYTES_WIDTH{1'b0}}};
  assign w_fill_addr   = {w_cpu_tag, w_cpu_idx, r_cnt, {WORD_BYTES_WIDTH{1'b0}}};
  assign w_idle_hit    = (r_state == ST_IDLE) && bus.cpu_en && bus.cache_hit;
  assign w_idle_miss   = (r_state == ST_IDLE) && bus.cpu_en && !bus.cache_hit;

  assign bus.cpu_dout  = bus.cache_dout;
  assign bus.cpu_stall = bus.cpu_en && !((r_state == ST_IDLE) && bus.cache_hit);

  // Array and memory strobes are decoded straight from the state so a hit completes with no wait state.
  always_comb begin
    // NOTE: every output gets a default before the case; a path that skips one would infer a latch.
    bus.cache_addr  = bus.cpu_addr;
    bus.cache_store = 1'b0;
    bus.cache_edit  = 1'b0;
    bus.cache_din   = bus.cpu_din;
    bus.mem_cs      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = w_fill_addr;
    bus.mem_dout    = bus.cache_dout;
    unique case (r_state)
      ST_IDLE: begin
        bus.cache_edit = w_idle_hit && bus.cpu_we;
      end
      ST_BACKUP: begin
        bus.cache_addr = w_backup_addr;
        bus.mem_addr   = w_backup_addr;
        bus.mem_cs     = 1'b1;
        bus.mem_we     = 1'b1;
      end
      ST_FILL: begin
        bus.cache_addr = w_fill_addr;
        bus.mem_cs     = 1'b1;
        if (bus.mem_ack) begin
          bus.cache_store = 1'b1;
          bus.cache_din   = bus.mem_din;
        end
      end
      ST_WAIT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_idle_miss) begin
            r_cnt   <= '0;
            r_state <= (bus.cache_valid && bus.cache_dirty) ? ST_BACKUP : ST_FILL;
          end
        end
        ST_BACKUP: begin
          if (bus.mem_ack) begin
            r_cnt <= r_cnt + LINE_WORDS_WIDTH'(1);
            if (r_cnt == '1) r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.mem_ack) begin
            r_cnt <= r_cnt + LINE_WORDS_WIDTH'(1);
            if (r_cnt == '1) r_state <= ST_WAIT;
          end
        end
        ST_WAIT: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The victim tag is captured while idle so the write-back address does not loop through the array's tag lookup.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath register with no reset; it is only consumed after an IDLE cycle has loaded it.
    if (r_state == ST_IDLE) r_victim_tag <= bus.cache_tag;
  end

`ifdef CACHE_CTRL_STAT_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        r_replay;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_replay     <= 1'b0;
    end else begin
      r_replay <= (r_state == ST_WAIT);
      if (w_idle_miss) r_miss_count <= r_miss_count + 32'd1;
      // The replayed access after a fill belongs to the miss already counted.
      if (w_idle_hit && !r_replay) r_hit_count <= r_hit_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
